// File: rtl/slow_mem_pkg.sv
// Shared types and constants for the slow line-memory responder.
// Imported by the storage array and the responder top.
package slow_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int LINE_W      = 128;
    localparam int MEM_ADDR_HI = 31;
    localparam int MEM_ADDR_LO = 4;

endpackage

// File: rtl/slow_mem_array.sv
// Line storage: synchronous write, combinational read.
// Contents are deliberately left unreset.
module slow_mem_array
    import slow_mem_pkg::*;
#(
    parameter int LINE_AW = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LINE_AW-1:0] addr,
    input  logic [LINE_W-1:0]  wdata,
    output logic [LINE_W-1:0]  rdata
);

    logic [LINE_W-1:0] mem_q [2**LINE_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency responder for the 128-bit cache line protocol.
// One access in flight; outputs decode only from registered state.
module slow_mem_responder
    import slow_mem_pkg::*;
#(
    parameter int LINE_AW = 8,
    parameter int LATENCY = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_read,
    input  logic                           mem_write,
    input  logic [MEM_ADDR_HI:MEM_ADDR_LO] mem_addr,
    input  logic [LINE_W-1:0]              mem_wdata,
    output logic [LINE_W-1:0]              mem_rdata,
    output logic                           mem_ready,
    output logic                           proto_err
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int ADDR_TOP = LINE_AW + MEM_ADDR_LO - 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [LINE_AW-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               perr_q, perr_d;

    logic               req;
    logic               arr_we;
    logic [LINE_W-1:0]  arr_rdata;
    logic               unused_addr;

    assign req = mem_read | mem_write;

    // High address bits alias by design.
    assign unused_addr = ^mem_addr[MEM_ADDR_HI:ADDR_TOP+1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        perr_d  = perr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    op_wr_d = mem_write;
                    addr_d  = mem_addr[ADDR_TOP:MEM_ADDR_LO];
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    perr_d  = perr_q | (mem_read & mem_write);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    perr_d = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            perr_q  <= perr_d;
        end
    end

    // Commit happens on the edge closing RESP; an async reset kills it.
    assign arr_we = (state_q == RESP) && op_wr_q;

    slow_mem_array #(
        .LINE_AW(LINE_AW)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = (state_q == RESP && !op_wr_q) ? arr_rdata : '0;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: transaction-level model plus directed
// and random traffic on a default instance and a LATENCY=1/LINE_AW=2 one.
module tb_slow_mem_responder;

    logic         clk;
    logic         rst_n;
    logic         rd [2];
    logic         wr [2];
    logic [27:0]  ad [2];
    logic [127:0] wd [2];
    logic [127:0] rdata [2];
    logic         rdy [2];
    logic         perr [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int lat [2] = '{8, 1};
    int amask [2] = '{255, 3};

    // Model state: one outstanding access per instance, counted in cycles.
    bit           busy [2];
    int           age [2];
    bit           opw [2];
    int           la [2];
    logic [127:0] ld [2];
    bit           perr_m [2];
    logic [127:0] mem_m [2][256];
    bit           wrt [2][256];

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;

    slow_mem_responder u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (rd[0]),
        .mem_write(wr[0]),
        .mem_addr (ad[0]),
        .mem_wdata(wd[0]),
        .mem_rdata(rdata[0]),
        .mem_ready(rdy[0]),
        .proto_err(perr[0])
    );

    slow_mem_responder #(
        .LINE_AW(2),
        .LATENCY(1)
    ) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (rd[1]),
        .mem_write(wr[1]),
        .mem_addr (ad[1]),
        .mem_wdata(wd[1]),
        .mem_rdata(rdata[1]),
        .mem_ready(rdy[1]),
        .proto_err(perr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int k,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at cycle %0d: got %h expected %h",
                     nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy[k]   = 1'b0;
                age[k]    = 0;
                perr_m[k] = 1'b0;
            end else if (busy[k]) begin
                if (age[k] == lat[k]) begin
                    if (opw[k]) begin
                        mem_m[k][la[k]] = ld[k];
                        wrt[k][la[k]]   = 1'b1;
                    end
                    busy[k] = 1'b0;
                end else begin
                    if (!(rd[k] | wr[k])) perr_m[k] = 1'b1;
                    age[k]++;
                end
            end else if (rd[k] | wr[k]) begin
                busy[k] = 1'b1;
                age[k]  = 1;
                opw[k]  = wr[k];
                la[k]   = int'(ad[k]) & amask[k];
                ld[k]   = wd[k];
                if (rd[k] & wr[k]) perr_m[k] = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    logic         er;
    logic [127:0] ed;
    bit           skip_d;

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            er     = busy[k] && (age[k] == lat[k]);
            skip_d = er && !opw[k] && !wrt[k][la[k]];
            ed     = (er && !opw[k]) ? mem_m[k][la[k]] : '0;
            chk("mem_ready", k, 128'(rdy[k]), 128'(er));
            chk("proto_err", k, 128'(perr[k]), 128'(perr_m[k]));
            if (!skip_d) chk("mem_rdata", k, rdata[k], ed);
        end
    end

    task automatic do_req(input int k, input logic r, input logic w,
                          input logic [27:0] a, input logic [127:0] d,
                          input int drop_at, output int n,
                          output logic [127:0] q, output int at);
        rd[k] = r;
        wr[k] = w;
        ad[k] = a;
        wd[k] = d;
        n  = 0;
        q  = '0;
        at = -1;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == drop_at) begin
                rd[k] = 1'b0;
                wr[k] = 1'b0;
            end
            if (rdy[k]) begin
                q  = rdata[k];
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout inst%0d: no mem_ready within %0d cycles", k, n);
        end
        @(posedge clk);
        #1;
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int           n, at1, at2, drop;
    logic [127:0] q, dat;
    logic [27:0]  a;
    int           k, sel;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = '0;
            wd[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_ready", 0, 128'(rdy[0]), 128'd0);
        chk("rst_rdata", 0, rdata[0], 128'd0);
        chk("rst_perr", 0, 128'(perr[0]), 128'd0);
        do_req(0, 1'b1, 1'b0, 28'h0000033, '0, 0, n, q, at1);
        chk("first_read_latency", 0, 128'(n), 128'd8);

        do_req(0, 1'b0, 1'b1, 28'h0000010, D0, 0, n, q, at1);
        chk("write_latency", 0, 128'(n), 128'd8);
        do_req(0, 1'b1, 1'b0, 28'h0000010, '0, 0, n, q, at1);
        chk("read_latency", 0, 128'(n), 128'd8);
        chk("read_data", 0, q, D0);

        do_req(0, 1'b0, 1'b1, 28'h0000040, ~D0, 0, n, q, at1);
        do_req(0, 1'b1, 1'b0, 28'h0000010, '0, 0, n, q, at2);
        chk("b2b_gap", 0, 128'(at2 - at1), 128'd9);
        chk("b2b_data", 0, q, D0);
        do_req(0, 1'b1, 1'b0, 28'h0000040, '0, 0, n, q, at1);
        chk("b2b_a_kept", 0, q, ~D0);

        do_req(1, 1'b0, 1'b1, 28'h0000001, 128'hA5, 0, n, q, at1);
        chk("alias_wr_latency", 1, 128'(n), 128'd1);
        do_req(1, 1'b1, 1'b0, 28'h0000005, '0, 0, n, q, at1);
        chk("alias_rd_latency", 1, 128'(n), 128'd1);
        chk("alias_data", 1, q, 128'hA5);

        do_req(0, 1'b1, 1'b1, 28'h0000050, 128'hBEEF, 0, n, q, at1);
        chk("both_perr", 0, 128'(perr[0]), 128'd1);
        do_req(0, 1'b1, 1'b0, 28'h0000050, '0, 0, n, q, at1);
        chk("both_as_write", 0, q, 128'hBEEF);

        do_reset();
        chk("perr_cleared", 0, 128'(perr[0]), 128'd0);
        do_req(0, 1'b1, 1'b0, 28'h0000010, '0, 3, n, q, at1);
        chk("drop_latency", 0, 128'(n), 128'd8);
        repeat (5) @(posedge clk);
        #1;
        chk("drop_perr_sticky", 0, 128'(perr[0]), 128'd1);
        do_reset();

        do_req(0, 1'b0, 1'b1, 28'h0000020, 128'hC0FFEE, 0, n, q, at1);
        rd[0] = 1'b0;
        wr[0] = 1'b1;
        ad[0] = 28'h0000020;
        wd[0] = 128'hDEAD;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst_n = 1'b0;
        wr[0] = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("abort_no_ready", 0, 128'(rdy[0]), 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(0, 1'b1, 1'b0, 28'h0000020, '0, 0, n, q, at1);
        chk("abort_no_commit", 0, q, 128'hC0FFEE);

        for (int it = 0; it < 160; it++) begin
            k   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 15));
            a   = 28'($urandom());
            if (k == 0) a[7:0] = 8'($urandom_range(0, 15));
            dat = {$urandom(), $urandom(), $urandom(), $urandom()};
            drop = 0;
            if (k == 0 && sel == 1) drop = int'($urandom_range(1, 7));
            if (sel == 0)
                do_req(k, 1'b1, 1'b1, a, dat, drop, n, q, at1);
            else if (sel[0])
                do_req(k, 1'b1, 1'b0, a, dat, drop, n, q, at1);
            else
                do_req(k, 1'b0, 1'b1, a, dat, drop, n, q, at1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
